// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared Tetris board, colour and render-state definitions
// Purpose: types and constants shared by the board renderer, its pixel counter
//          and the later piece overlay.
// Ports:   none (package).
package tetris_pkg;

    typedef logic [2:0] color_t;

    localparam color_t COLOR_EMPTY = 3'd0;
    localparam color_t COLOR_GRID  = 3'd7;

    localparam int BOARD_W  = 10;
    localparam int BOARD_H  = 20;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [2:0] {
        RS_IDLE,
        RS_WAIT_CLR,
        RS_FETCH,
        RS_RD_WAIT,
        RS_DRAW,
        RS_NEXT,
        RS_DONE
    } render_state_t;

endpackage

// File: rtl/board_renderer_if.sv
// rtl/board_renderer_if.sv - control, board-RAM and pixel-write bundle of the board renderer
// Purpose: groups every non-clock/reset signal of board_renderer.
// Ports:   master drives start/clear_done/cell_data and observes the rest;
//          slave (the renderer) is the mirror image.
interface board_renderer_if;

    logic                start;
    logic                clear_done;
    logic [4:0]          cell_row;
    logic [3:0]          cell_col;
    logic                cell_rd;
    tetris_pkg::color_t  cell_data;
    logic [10:0]         x;
    logic [10:0]         y;
    tetris_pkg::color_t  pixel_color;
    logic                pixel_we;
    logic                busy;
    logic                done;

    modport master (
        output start, clear_done, cell_data,
        input  cell_row, cell_col, cell_rd, x, y, pixel_color, pixel_we, busy, done
    );

    modport slave (
        input  start, clear_done, cell_data,
        output cell_row, cell_col, cell_rd, x, y, pixel_color, pixel_we, busy, done
    );

endinterface

// File: rtl/cell_pixel_counter.sv
// rtl/cell_pixel_counter.sv - px/py scan counter over one CELL_PX x CELL_PX cell
// Purpose: px is the fast index, py the slow one; last flags the final pixel.
// Ports:   clk, reset (async, active-high), clear (sync to 0), enable (advance),
//          px, py (current pixel in cell), last (px and py both at CELL_PX-1).
module cell_pixel_counter #(
    parameter  int CELL_PX = 16,
    localparam int PW      = $clog2(CELL_PX)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [PW-1:0] px,
    output logic [PW-1:0] py,
    output logic          last
);

    localparam logic [PW-1:0] PMAX = PW'(CELL_PX - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px <= '0;
            py <= '0;
        end else if (clear) begin
            px <= '0;
            py <= '0;
        end else if (enable) begin
            // CELL_PX is a power of two, so both indices wrap to 0 naturally
            px <= px + 1'b1;
            if (px == PMAX) begin
                py <= py + 1'b1;
            end
        end
    end

    assign last = (px == PMAX) && (py == PMAX);

endmodule

// File: rtl/board_renderer.sv
// rtl/board_renderer.sv - walks the Tetris board and writes pixels for occupied cells
// Purpose: after the clear sweep finishes, reads each board cell once and paints
//          every non-empty cell as a CELL_PX square with a COLOR_GRID outline.
// Ports:   clk, reset (async, active-high);
//          bus.start/clear_done   frame request / sweeper finished level
//          bus.cell_row/col/rd    board RAM read (data one cycle later on cell_data)
//          bus.x/y/pixel_color/pixel_we  registered framebuffer write
//          bus.busy/done          activity level / end-of-frame pulse
module board_renderer
    import tetris_pkg::*;
#(
    parameter int BOARD_W  = tetris_pkg::BOARD_W,
    parameter int BOARD_H  = tetris_pkg::BOARD_H,
    parameter int CELL_PX  = 16,
    parameter int ORIGIN_X = 240,
    parameter int ORIGIN_Y = 80
) (
    input logic              clk,
    input logic              reset,
    board_renderer_if.slave  bus
);

    localparam int PXW = $clog2(CELL_PX);
    localparam logic [PXW-1:0] PMAX = PXW'(CELL_PX - 1);

    if (ORIGIN_X + BOARD_W * CELL_PX > SCREEN_W ||
        ORIGIN_Y + BOARD_H * CELL_PX > SCREEN_H) begin : g_bad_geometry
        $error("board_renderer: board does not fit on the screen");
    end
    if (CELL_PX < 2 || (CELL_PX & (CELL_PX - 1)) != 0) begin : g_bad_cell
        $error("board_renderer: CELL_PX must be a power of two >= 2");
    end
    if (BOARD_W > 16 || BOARD_H > 32) begin : g_bad_board
        $error("board_renderer: board exceeds cell_row/cell_col width");
    end

    render_state_t  state, state_nx;
    logic [4:0]     row;
    logic [3:0]     col;
    color_t         colour;
    logic           clr_q;
    logic [PXW-1:0] px, py;
    logic           last_px;
    logic           last_cell;
    logic           outline;

    logic [10:0]    x_q, y_q;
    color_t         color_q;
    logic           we_q;

    assign last_cell = (row == 5'(BOARD_H - 1)) && (col == 4'(BOARD_W - 1));
    assign outline   = (px == '0) || (px == PMAX) || (py == '0) || (py == PMAX);

    cell_pixel_counter #(
        .CELL_PX (CELL_PX)
    ) u_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == RS_FETCH),
        .enable (state == RS_DRAW),
        .px     (px),
        .py     (py),
        .last   (last_px)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RS_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            RS_IDLE:     if (bus.start) state_nx = RS_WAIT_CLR;
            // clr_q is one cycle behind clear_done; an already-high flag
            // therefore lets WAIT_CLR last exactly one cycle
            RS_WAIT_CLR: if (clr_q) state_nx = RS_FETCH;
            RS_FETCH:    state_nx = RS_RD_WAIT;
            RS_RD_WAIT:  state_nx = (bus.cell_data == COLOR_EMPTY) ? RS_NEXT : RS_DRAW;
            RS_DRAW:     if (last_px) state_nx = RS_NEXT;
            RS_NEXT:     state_nx = last_cell ? RS_DONE : RS_FETCH;
            RS_DONE:     state_nx = RS_IDLE;
            default:     state_nx = RS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row    <= '0;
            col    <= '0;
            colour <= COLOR_EMPTY;
            clr_q  <= 1'b0;
        end else begin
            clr_q <= bus.clear_done;
            if (state == RS_IDLE && bus.start) begin
                row <= '0;
                col <= '0;
            end
            if (state == RS_RD_WAIT) begin
                colour <= bus.cell_data;
            end
            if (state == RS_NEXT) begin
                if (col == 4'(BOARD_W - 1)) begin
                    col <= '0;
                    row <= last_cell ? 5'd0 : row + 5'd1;
                end else begin
                    col <= col + 4'd1;
                end
            end
        end
    end

    // Pixel write is registered as a group; coordinates and colour hold
    // their last value whenever no write is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            color_q <= COLOR_EMPTY;
            we_q    <= 1'b0;
        end else begin
            we_q <= (state == RS_DRAW);
            if (state == RS_DRAW) begin
                x_q     <= 11'(ORIGIN_X) + (11'(col) << PXW) + 11'(px);
                y_q     <= 11'(ORIGIN_Y) + (11'(row) << PXW) + 11'(py);
                color_q <= outline ? COLOR_GRID : colour;
            end
        end
    end

    assign bus.cell_row    = row;
    assign bus.cell_col    = col;
    assign bus.cell_rd     = (state == RS_FETCH);
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.pixel_color = color_q;
    assign bus.pixel_we    = we_q;
    assign bus.busy        = (state != RS_IDLE);
    assign bus.done        = (state == RS_DONE);

endmodule

// File: tb/tb_board_renderer.sv
// tb/tb_board_renderer.sv - directed self-checking bench for board_renderer
module tb_board_renderer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    board_renderer_if bus ();

    board_renderer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [2:0] board [20][10];

    always @(posedge clk) begin
        if (bus.cell_rd) bus.cell_data <= board[bus.cell_row][bus.cell_col];
    end

    int errors = 0;
    int checks = 0;

    logic [10:0] exp_ox  = 11'd240;
    logic [10:0] exp_oy  = 11'd80;
    logic [2:0]  exp_col = 3'd3;

    int          wr_cnt   = 0;
    int          rd_cnt   = 0;
    int          done_cnt = 0;
    int          bad_cnt  = 0;
    logic [10:0] last_x   = '0;
    logic [10:0] last_y   = '0;
    logic [2:0]  seen_241 = '0;

    always @(negedge clk) begin
        if (bus.cell_rd) rd_cnt++;
        if (bus.done) done_cnt++;
        if (bus.pixel_we) begin
            wr_cnt++;
            last_x = bus.x;
            last_y = bus.y;
            if (bus.x == 11'd241 && bus.y == 11'd81) seen_241 = bus.pixel_color;
            if (bus.x < exp_ox || bus.x > exp_ox + 11'd15 ||
                bus.y < exp_oy || bus.y > exp_oy + 11'd15) begin
                bad_cnt++;
            end else if (bus.x == exp_ox || bus.x == exp_ox + 11'd15 ||
                         bus.y == exp_oy || bus.y == exp_oy + 11'd15) begin
                if (bus.pixel_color !== 3'd7) bad_cnt++;
            end else if (bus.pixel_color !== exp_col) begin
                bad_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output logic prev_we);
        cyc = 0;
        prev_we = 1'b0;
        while (!bus.done && cyc < 3000) begin
            prev_we = bus.pixel_we;
            @(negedge clk);
            cyc++;
        end
        check("done_timeout", 32'(cyc < 3000), 1);
    endtask

    task automatic wait_we();
        int n;
        n = 0;
        while (!bus.pixel_we && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("we_timeout", 32'(n < 100), 1);
    endtask

    task automatic set_only(input int r, input int c, input logic [2:0] v);
        for (int i = 0; i < 20; i++)
            for (int j = 0; j < 10; j++)
                board[i][j] = 3'd0;
        if (v != 3'd0) board[r][c] = v;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int   cyc, rd0, wr0, dn0, bad0;
        logic pw;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.clear_done = 1'b0;
        set_only(0, 0, 3'd0);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", bus.busy, 0);
        check("rst_we", bus.pixel_we, 0);
        check("rst_done", bus.done, 0);
        check("rst_rd", bus.cell_rd, 0);
        check("rst_x", bus.x, 0);
        check("rst_y", bus.y, 0);
        reset = 1'b0;
        @(negedge clk);

        // WAIT_CLR holds while the sweeper is still running
        rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
        pulse_start();
        repeat (50) @(negedge clk);
        #1;
        check("wait_no_rd", rd_cnt - rd0, 0);
        check("wait_busy", bus.busy, 1);
        bus.clear_done = 1'b1;
        @(negedge clk);
        check("clr_rd_1cyc", bus.cell_rd, 0);
        @(negedge clk);
        check("clr_rd_2cyc", bus.cell_rd, 1);
        check("clr_row", bus.cell_row, 0);
        check("clr_col", bus.cell_col, 0);

        // Empty board: 200 reads, no writes, done 600 cycles after first FETCH
        wait_done(cyc, pw);
        check("empty_cycles", cyc, 600);
        #1;
        check("empty_rd_cnt", rd_cnt - rd0, 200);
        check("empty_wr_cnt", wr_cnt - wr0, 0);
        check("empty_done_cnt", done_cnt - dn0, 1);
        @(negedge clk);
        check("empty_idle_busy", bus.busy, 0);
        check("empty_idle_done", bus.done, 0);

        // Cell (0,0) = 3
        set_only(0, 0, 3'd3);
        exp_ox = 11'd240; exp_oy = 11'd80; exp_col = 3'd3;
        wr0 = wr_cnt; bad0 = bad_cnt;
        pulse_start();
        wait_we();
        check("c00_first_x", bus.x, 240);
        check("c00_first_y", bus.y, 80);
        check("c00_first_color", bus.pixel_color, 7);
        wait_done(cyc, pw);
        #1;
        check("c00_wr_cnt", wr_cnt - wr0, 256);
        check("c00_bad", bad_cnt - bad0, 0);
        check("c00_241_81", seen_241, 3);
        check("c00_last_x", last_x, 255);
        check("c00_last_y", last_y, 95);

        // Cell (19,9) = 5: last cell, done right after final write
        set_only(19, 9, 3'd5);
        exp_ox = 11'd384; exp_oy = 11'd384; exp_col = 3'd5;
        @(negedge clk);
        wr0 = wr_cnt; bad0 = bad_cnt;
        pulse_start();
        wait_done(cyc, pw);
        #1;
        check("c199_wr_cnt", wr_cnt - wr0, 256);
        check("c199_bad", bad_cnt - bad0, 0);
        check("c199_last_x", last_x, 399);
        check("c199_last_y", last_y, 399);
        check("c199_we_before_done", pw, 1);

        // start held high while busy and through DONE: exactly one frame
        @(negedge clk);
        wr0 = wr_cnt; dn0 = done_cnt;
        bus.start = 1'b1;
        @(negedge clk);
        wait_done(cyc, pw);
        @(negedge clk);
        check("hold_idle_busy", bus.busy, 0);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("hold_still_idle", bus.busy, 0);
        check("hold_wr_cnt", wr_cnt - wr0, 256);
        check("hold_done_cnt", done_cnt - dn0, 1);

        // start one cycle after done begins a new frame
        wr0 = wr_cnt;
        pulse_start();
        wait_done(cyc, pw);
        @(negedge clk);
        pulse_start();
        check("restart_busy", bus.busy, 1);
        wait_done(cyc, pw);
        #1;
        check("restart_wr_cnt", wr_cnt - wr0, 512);

        // Reset in the middle of DRAW
        set_only(0, 0, 3'd3);
        exp_ox = 11'd240; exp_oy = 11'd80; exp_col = 3'd3;
        @(negedge clk);
        pulse_start();
        wait_we();
        repeat (20) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_we", bus.pixel_we, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_x", bus.x, 0);
        check("mid_rst_y", bus.y, 0);
        check("mid_rst_color", bus.pixel_color, 0);
        @(negedge clk);
        reset = 1'b0;
        wr0 = wr_cnt;
        repeat (30) @(negedge clk);
        #1;
        check("post_rst_wr", wr_cnt - wr0, 0);
        check("post_rst_busy", bus.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
